dual_port_ram_be: RTL and testbench
===================================

// Module: dual_port_ram_be
// PURPOSE
//  True dual-port synchronous RAM, next generation of the team's dual-port RAM.
//  Adds byte-lane write enables, per-port read-during-write mode, an optional output register,
//  deterministic same-address collision resolution and a self-clearing init sequencer.
//  Shared scratch/buffer memory between two independent masters on one clock domain.
// PARAMETERS
//  DATA_WIDTH  8  word width in bits; must be a multiple of BYTE_WIDTH
//  ADDR_WIDTH  4  address width; DEPTH = 2**ADDR_WIDTH words
//  BYTE_WIDTH  8  bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
//  RDW_MODE_A  0  port A same-port read-during-write: 0 = READ_FIRST (old word), 1 = WRITE_FIRST (new word)
//  RDW_MODE_B  0  port B, same encoding as RDW_MODE_A
//  OUT_REG     0  1 = extra output pipeline register (read latency 2), 0 = latency 1
// PORTS
//  clk        in   1           clock, all logic on the rising edge
//  rst        in   1           synchronous reset, active-high
//  en_a       in   1           port A access request (read, or write if any we_a bit is set)
//  we_a       in   NB          port A byte-lane write enables
//  addr_a     in   ADDR_WIDTH  port A word address
//  din_a      in   DATA_WIDTH  port A write data
//  dout_a     out  DATA_WIDTH  port A read data
//  vld_a      out  1           dout_a valid strobe
//  en_b/we_b/addr_b/din_b/dout_b/vld_b  same as port A, for port B
//  collision  out  1           same-address access on both ports (registered pulse)
//  ready      out  1           init clear done; accesses are accepted only when high
// BEHAVIOUR
//  Reset (rst=1 on a clock edge):
//   - ready=0, vld_a=vld_b=0, dout_a=dout_b=0, collision=0; sequencer enters CLEAR with clr_addr=0.
//  FSM CLEAR -> RUN:
//   - CLEAR: each cycle with rst=0, writes 0 to mem[clr_addr] and increments clr_addr.
//   - After the write to DEPTH-1, go to RUN; ready=1 from the DEPTH-th edge after rst falls.
//   - In CLEAR, port inputs are ignored: no writes, vld stays 0.
//   - rst in any state (including mid-CLEAR) restarts CLEAR at address 0. Contents are cleared again.
//  Access (RUN only):
//   - en_x=1 at edge t issues an access.
//   - vld_x=1 and dout_x valid at edge t+1 (OUT_REG=0) or t+2 (OUT_REG=1), for one cycle per access.
//   - Back-to-back accesses are fully pipelined: one per cycle per port.
//   - While vld_x=0, dout_x holds its last value.
//   - Lane i is written with din_x[i*BYTE_WIDTH +: BYTE_WIDTH] when we_x[i]=1; other lanes are unchanged.
//   - en_x=0 means no write regardless of we_x.
//   - Every enabled access returns read data. On a write cycle:
//     - READ_FIRST returns the pre-write word.
//     - WRITE_FIRST returns the pre-write word with this port's enabled lanes replaced by din_x.
//  Collision (RUN, en_a=en_b=1, addr_a==addr_b):
//   - collision=1 at edge t+1, independent of OUT_REG; otherwise 0.
//   - Lanes written by both ports take port A data. Lanes written by only one port take that port's data.
//   - A port reading the other port's write target sees the pre-write word; its own WRITE_FIRST rule still applies.
//  No wrap or overflow: addresses are exactly ADDR_WIDTH bits; clr_addr wraps only when CLEAR exits.
// TESTING (DATA_WIDTH=16, BYTE_WIDTH=8, ADDR_WIDTH=4 unless stated)
//  1. Clear: rst high 2 cycles then low -> ready=0 for 16 cycles, then 1; read all 16 addresses -> every dout=0x0000.
//  2. Byte write: A writes addr 3, din 0xABCD, we 2'b11; then din 0x1234, we 2'b01; read addr 3 -> 0xAB34.
//  3. RDW: mem[5]=0xAAAA, A writes 0x5555 full lanes -> dout_a=0xAAAA (RDW_MODE_A=0), 0x5555 (RDW_MODE_A=1).
//  4. Collision:
//     - Same cycle, addr 7, A din 0x1111, B din 0x2222, both we 2'b11 -> mem[7]=0x1111, collision=1 one cycle later.
//     - Repeat with A we 2'b01, B we 2'b10 -> mem[7]=0x2211.
//  5. Latency: OUT_REG=1, reads on A at cycles t and t+1 -> vld_a high at t+2 and t+3 with the correct words; dout_a holds afterwards.
//  6. Mid-clear reset: rst pulsed at clear cycle 8 -> ready low for 16 more cycles. A writes issued during CLEAR are lost (read back 0).

Source files
------------

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte-lane write enables, per-port read-during-write mode,
// optional output register, port-A-wins collision merge and a clear-on-reset sequencer.
module dual_port_ram_be #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE_A = 0,
  parameter int RDW_MODE_B = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            din_a,
  output logic [DATA_WIDTH-1:0]            dout_a,
  output logic                             vld_a,
  input  logic                             en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            din_b,
  output logic [DATA_WIDTH-1:0]            dout_b,
  output logic                             vld_b,
  output logic                             collision,
  output logic                             ready
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_last;
  logic                  w_acc_a;
  logic                  w_acc_b;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;
  logic                  r_v1_a;
  logic                  r_v1_b;
  logic [DATA_WIDTH-1:0] r_q1_a;
  logic [DATA_WIDTH-1:0] r_q1_b;
  logic                  r_coll;

  assign ready   = (r_state == S_RUN);
  assign w_last  = (r_clr_addr == ADDR_WIDTH'(DEPTH - 1));
  assign w_acc_a = ready && en_a;
  assign w_acc_b = ready && en_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (w_last) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Port A lanes are assigned last so they win when both ports write the same lane.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_addr] <= '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (w_acc_b && we_b[i])
            r_mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
          if (w_acc_a && we_a[i])
            r_mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Only the port's own lanes are forwarded; the other port's write is never visible same-cycle.
  always_comb begin
    w_rd_a = r_mem[addr_a];
    w_rd_b = r_mem[addr_b];
    for (int i = 0; i < NB; i++) begin
      if (RDW_MODE_A != 0 && we_a[i])
        w_rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (RDW_MODE_B != 0 && we_b[i])
        w_rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1_a <= 1'b0;
      r_v1_b <= 1'b0;
      r_q1_a <= '0;
      r_q1_b <= '0;
      r_coll <= 1'b0;
    end else begin
      r_v1_a <= w_acc_a;
      r_v1_b <= w_acc_b;
      if (w_acc_a) r_q1_a <= w_rd_a;
      if (w_acc_b) r_q1_b <= w_rd_b;
      r_coll <= w_acc_a && w_acc_b && (addr_a == addr_b);
    end
  end

  assign collision = r_coll;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_v2_a;
      logic                  r_v2_b;
      logic [DATA_WIDTH-1:0] r_q2_a;
      logic [DATA_WIDTH-1:0] r_q2_b;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v2_a <= 1'b0;
          r_v2_b <= 1'b0;
          r_q2_a <= '0;
          r_q2_b <= '0;
        end else begin
          r_v2_a <= r_v1_a;
          r_v2_b <= r_v1_b;
          if (r_v1_a) r_q2_a <= r_q1_a;
          if (r_v1_b) r_q2_b <= r_q1_b;
        end
      end

      assign dout_a = r_q2_a;
      assign dout_b = r_q2_b;
      assign vld_a  = r_v2_a;
      assign vld_b  = r_v2_b;
    end else begin : g_no_out_reg
      assign dout_a = r_q1_a;
      assign dout_b = r_q1_b;
      assign vld_a  = r_v1_a;
      assign vld_b  = r_v1_b;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: u0 = latency 1, A read-first, B write-first; u1 = latency 2, A write-first, B read-first.
// Both instances see identical stimulus.
module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [1:0]  we_a, we_b;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b;

  logic [15:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic        vld_a0, vld_b0, vld_a1, vld_b1;
  logic        coll0, coll1, ready0, ready1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_port_ram_be #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .RDW_MODE_A(0), .RDW_MODE_B(1), .OUT_REG(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0), .vld_a(vld_a0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b0), .vld_b(vld_b0),
    .collision(coll0), .ready(ready0)
  );

  dual_port_ram_be #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
    .RDW_MODE_A(1), .RDW_MODE_B(0), .OUT_REG(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .vld_a(vld_a1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .vld_b(vld_b1),
    .collision(coll1), .ready(ready1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 2'b00; addr_a = 4'h0; din_a = 16'h0000;
    en_b = 1'b0; we_b = 2'b00; addr_b = 4'h0; din_b = 16'h0000;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on each port (either may be disabled), then the results of both instances.
  task automatic step(input string tag,
                      input logic ea, input logic [1:0] wa, input logic [3:0] aa, input logic [15:0] da,
                      input logic eb, input logic [1:0] wb, input logic [3:0] ab, input logic [15:0] db,
                      input logic [15:0] xa0, input logic [15:0] xb0,
                      input logic [15:0] xa1, input logic [15:0] xb1,
                      input logic xcoll);
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    tick();
    idle();
    chk({tag, ":vld_a0"}, 16'(vld_a0), 16'(ea));
    if (ea) chk({tag, ":dout_a0"}, dout_a0, xa0);
    chk({tag, ":vld_b0"}, 16'(vld_b0), 16'(eb));
    if (eb) chk({tag, ":dout_b0"}, dout_b0, xb0);
    chk({tag, ":coll0"}, 16'(coll0), 16'(xcoll));
    chk({tag, ":coll1"}, 16'(coll1), 16'(xcoll));
    chk({tag, ":vld_a1_early"}, 16'(vld_a1), 16'h0);
    tick();
    chk({tag, ":vld_a1"}, 16'(vld_a1), 16'(ea));
    if (ea) chk({tag, ":dout_a1"}, dout_a1, xa1);
    chk({tag, ":vld_b1"}, 16'(vld_b1), 16'(eb));
    if (eb) chk({tag, ":dout_b1"}, dout_b1, xb1);
    chk({tag, ":vld_a0_drop"}, 16'(vld_a0), 16'h0);
    chk({tag, ":coll0_drop"}, 16'(coll0), 16'h0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst:ready0", 16'(ready0), 16'h0);
    chk("rst:ready1", 16'(ready1), 16'h0);
    chk("rst:vld_a0", 16'(vld_a0), 16'h0);
    chk("rst:vld_b1", 16'(vld_b1), 16'h0);
    chk("rst:dout_a0", dout_a0, 16'h0000);
    chk("rst:dout_b1", dout_b1, 16'h0000);
    chk("rst:coll0", 16'(coll0), 16'h0);

    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("clear:ready0_c%0d", c), 16'(ready0), 16'(c == 16));
      chk($sformatf("clear:ready1_c%0d", c), 16'(ready1), 16'(c == 16));
    end

    for (int i = 0; i < 16; i++)
      step($sformatf("clrrd%0d", i), 1'b1, 2'b00, 4'(i), 16'h0, 1'b1, 2'b00, 4'(15 - i), 16'h0,
           16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    // byte-lane writes
    step("bw_full", 1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, 2'b00, 4'd0, 16'h0,
         16'h0000, 16'h0000, 16'hABCD, 16'h0000, 1'b0);
    step("bw_low", 1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, 2'b00, 4'd0, 16'h0,
         16'hABCD, 16'h0000, 16'hAB34, 16'h0000, 1'b0);
    step("bw_noen", 1'b0, 2'b11, 4'd3, 16'hFFFF, 1'b0, 2'b11, 4'd3, 16'hFFFF,
         16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step("bw_rd", 1'b1, 2'b00, 4'd3, 16'h0, 1'b1, 2'b00, 4'd3, 16'h0,
         16'hAB34, 16'hAB34, 16'hAB34, 16'hAB34, 1'b1);

    // read-during-write on each port
    step("rdw_init", 1'b1, 2'b11, 4'd5, 16'hAAAA, 1'b0, 2'b00, 4'd0, 16'h0,
         16'h0000, 16'h0000, 16'hAAAA, 16'h0000, 1'b0);
    step("rdw_full", 1'b1, 2'b11, 4'd5, 16'h5555, 1'b0, 2'b00, 4'd0, 16'h0,
         16'hAAAA, 16'h0000, 16'h5555, 16'h0000, 1'b0);
    step("rdw_part", 1'b1, 2'b01, 4'd5, 16'h1234, 1'b0, 2'b00, 4'd0, 16'h0,
         16'h5555, 16'h0000, 16'h5534, 16'h0000, 1'b0);
    step("rdw_b", 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 2'b01, 4'd9, 16'h00FF,
         16'h0000, 16'h00FF, 16'h0000, 16'h0000, 1'b0);
    step("rdw_rd", 1'b1, 2'b00, 4'd5, 16'h0, 1'b1, 2'b00, 4'd9, 16'h0,
         16'h5534, 16'h00FF, 16'h5534, 16'h00FF, 1'b0);

    // same-address collisions
    step("col_full", 1'b1, 2'b11, 4'd7, 16'h1111, 1'b1, 2'b11, 4'd7, 16'h2222,
         16'h0000, 16'h2222, 16'h1111, 16'h0000, 1'b1);
    step("col_rd1", 1'b1, 2'b00, 4'd7, 16'h0, 1'b1, 2'b00, 4'd7, 16'h0,
         16'h1111, 16'h1111, 16'h1111, 16'h1111, 1'b1);
    step("col_split", 1'b1, 2'b01, 4'd7, 16'h1111, 1'b1, 2'b10, 4'd7, 16'h2222,
         16'h1111, 16'h2211, 16'h1111, 16'h1111, 1'b1);
    step("col_rd2", 1'b1, 2'b00, 4'd7, 16'h0, 1'b1, 2'b00, 4'd8, 16'h0,
         16'h2211, 16'h0000, 16'h2211, 16'h0000, 1'b0);
    step("col_noenb", 1'b1, 2'b00, 4'd7, 16'h0, 1'b0, 2'b00, 4'd7, 16'h0,
         16'h2211, 16'h0000, 16'h2211, 16'h0000, 1'b0);

    // back-to-back reads on A
    en_a = 1'b1; addr_a = 4'd3;
    tick();
    chk("pipe:t1_vld_a0", 16'(vld_a0), 16'h1);
    chk("pipe:t1_dout_a0", dout_a0, 16'hAB34);
    chk("pipe:t1_vld_a1", 16'(vld_a1), 16'h0);
    addr_a = 4'd5;
    tick();
    idle();
    chk("pipe:t2_dout_a0", dout_a0, 16'h5534);
    chk("pipe:t2_vld_a1", 16'(vld_a1), 16'h1);
    chk("pipe:t2_dout_a1", dout_a1, 16'hAB34);
    tick();
    chk("pipe:t3_vld_a0", 16'(vld_a0), 16'h0);
    chk("pipe:t3_hold_a0", dout_a0, 16'h5534);
    chk("pipe:t3_vld_a1", 16'(vld_a1), 16'h1);
    chk("pipe:t3_dout_a1", dout_a1, 16'h5534);
    tick();
    chk("pipe:t4_vld_a1", 16'(vld_a1), 16'h0);
    chk("pipe:t4_hold_a1", dout_a1, 16'h5534);

    // reset mid-clear, with writes attempted throughout the clear
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_a = 1'b1; we_a = 2'b11; addr_a = 4'd0; din_a = 16'hBEEF;
    for (int c = 1; c <= 8; c++) tick();
    chk("mid:ready_c8", 16'(ready0), 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("mid:ready0_c%0d", c), 16'(ready0), 16'(c == 16));
      chk($sformatf("mid:ready1_c%0d", c), 16'(ready1), 16'(c == 16));
      chk($sformatf("mid:vld_a0_c%0d", c), 16'(vld_a0), 16'h0);
    end
    idle();
    step("mid_rd", 1'b1, 2'b00, 4'd0, 16'h0, 1'b1, 2'b00, 4'd3, 16'h0,
         16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
